// File: rtl/player_motion_ctrl.sv
// Player motion controller: clamped vertical stepping with hold-to-repeat,
// and a wrapping horizontal scroll offset advanced once per vsync frame.
module player_motion_ctrl #(
    parameter int HEIGHT        = 768,
    parameter int WIDTH         = 1024,
    parameter int VW            = 10,
    parameter int HW            = 11,
    parameter int V_STEP        = 100,
    parameter int V_INIT        = 384,
    parameter int REPEAT_FRAMES = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          vsync,
    input  logic          up,
    input  logic          down,
    input  logic          pause,
    input  logic [3:0]    speed,
    output logic [VW-1:0] p_vpos,
    output logic [HW-1:0] p_offset,
    output logic          frame_tick,
    output logic          at_top,
    output logic          at_bottom
);
    localparam int CW = $clog2(REPEAT_FRAMES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(REPEAT_FRAMES - 1);
    localparam logic [VW-1:0] STEP     = VW'(V_STEP);
    localparam logic [VW-1:0] VMAX     = VW'(HEIGHT - 1);
    localparam logic [VW-1:0] DN_LIM   = VW'(HEIGHT - 1 - V_STEP);
    localparam logic [HW:0]   WRAP     = (HW+1)'(WIDTH);

    typedef enum logic [1:0] {IDLE, HOLD_UP, HOLD_DOWN} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [VW-1:0] vpos_q;
    logic [HW-1:0] offset_q, offset_d;
    logic [HW:0]   sum;
    logic          tick_q;
    logic          vsync_q, up_q, down_q;
    logic          up_arm_q, down_arm_q;
    logic          up_press, down_press;

    function automatic logic [VW-1:0] step_up(input logic [VW-1:0] v);
        return (v < STEP) ? '0 : v - STEP;
    endfunction

    function automatic logic [VW-1:0] step_down(input logic [VW-1:0] v);
        return (v > DN_LIM) ? VMAX : v + STEP;
    endfunction

    always_comb begin
        sum      = {1'b0, offset_q} + (HW+1)'(speed);
        offset_d = offset_q;
        if (tick_q && !pause)
            offset_d = (sum >= WRAP) ? HW'(sum - WRAP) : sum[HW-1:0];
        // A button held through reset must be released before it can step again.
        up_press   = up & ~up_q & ~down & up_arm_q;
        down_press = down & ~down_q & ~up & down_arm_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            vpos_q     <= VW'(V_INIT);
            offset_q   <= '0;
            tick_q     <= 1'b0;
            vsync_q    <= 1'b0;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            up_arm_q   <= ~up;
            down_arm_q <= ~down;
        end else begin
            vsync_q    <= vsync;
            up_q       <= up;
            down_q     <= down;
            up_arm_q   <= up_arm_q | ~up;
            down_arm_q <= down_arm_q | ~down;
            tick_q     <= vsync & ~vsync_q;
            offset_q   <= offset_d;
            case (state_q)
                IDLE: begin
                    if (up_press) begin
                        vpos_q  <= step_up(vpos_q);
                        cnt_q   <= '0;
                        state_q <= HOLD_UP;
                    end else if (down_press) begin
                        vpos_q  <= step_down(vpos_q);
                        cnt_q   <= '0;
                        state_q <= HOLD_DOWN;
                    end
                end
                HOLD_UP: begin
                    if (!up || down) begin
                        state_q <= IDLE;
                    end else if (tick_q) begin
                        if (cnt_q == CNT_LAST) begin
                            vpos_q <= step_up(vpos_q);
                            cnt_q  <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                HOLD_DOWN: begin
                    if (!down || up) begin
                        state_q <= IDLE;
                    end else if (tick_q) begin
                        if (cnt_q == CNT_LAST) begin
                            vpos_q <= step_down(vpos_q);
                            cnt_q  <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign p_vpos     = vpos_q;
    assign p_offset   = offset_q;
    assign frame_tick = tick_q;
    assign at_top     = (vpos_q == '0);
    assign at_bottom  = (vpos_q == VMAX);
endmodule

// File: tb/tb_player_motion_ctrl.sv
// Bench for player_motion_ctrl: table-driven stepping vectors, directed
// multi-cycle sequences, and randomized stimulus checked against a frame-level model.
module tb_player_motion_ctrl;
    localparam int HEIGHT = 768;
    localparam int WIDTH  = 1024;
    localparam int V_STEP = 100;
    localparam int V_INIT = 384;
    localparam int REPEAT = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        vsync = 1'b0;
    logic        up = 1'b0, down = 1'b0, pause = 1'b0;
    logic [3:0]  speed = 4'd0;
    logic [9:0]  p_vpos;
    logic [10:0] p_offset;
    logic        frame_tick, at_top, at_bottom;

    player_motion_ctrl dut (
        .clock(clock), .reset(reset), .vsync(vsync), .up(up), .down(down),
        .pause(pause), .speed(speed), .p_vpos(p_vpos), .p_offset(p_offset),
        .frame_tick(frame_tick), .at_top(at_top), .at_bottom(at_bottom)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int tick_cnt = 0;

    // Model state: position, offset, pending tick, previous input samples,
    // hold direction (-1 up, +1 down, 0 none), ticks seen since last step.
    int m_v, m_off, m_tick, m_pv, m_pu, m_pd, m_hold, m_frames;
    int m_uok, m_dok;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp(input int v);
        if (v < 0) return 0;
        if (v > HEIGHT - 1) return HEIGHT - 1;
        return v;
    endfunction

    task automatic model_step();
        int nt, held, opp;
        if (reset) begin
            m_v = V_INIT; m_off = 0; m_tick = 0;
            m_pv = 0; m_pu = 0; m_pd = 0; m_hold = 0; m_frames = 0;
            m_uok = !up; m_dok = !down;
        end else begin
            nt = (vsync && !m_pv) ? 1 : 0;
            if (m_tick != 0 && !pause) m_off = (m_off + int'(speed)) % WIDTH;
            if (m_hold == 0) begin
                if (up && !m_pu && !down && m_uok != 0) begin
                    m_v = clamp(m_v - V_STEP); m_hold = -1; m_frames = 0;
                end else if (down && !m_pd && !up && m_dok != 0) begin
                    m_v = clamp(m_v + V_STEP); m_hold = 1; m_frames = 0;
                end
            end else begin
                held = (m_hold < 0) ? int'(up) : int'(down);
                opp  = (m_hold < 0) ? int'(down) : int'(up);
                if (held == 0 || opp != 0) begin
                    m_hold = 0;
                end else if (m_tick != 0) begin
                    m_frames++;
                    if (m_frames == REPEAT) begin
                        m_v = clamp(m_v + m_hold * V_STEP);
                        m_frames = 0;
                    end
                end
            end
            if (!up) m_uok = 1;
            if (!down) m_dok = 1;
            m_pv = int'(vsync); m_pu = int'(up); m_pd = int'(down);
            m_tick = nt;
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        model_step();
        #1;
        if (frame_tick) tick_cnt++;
        chk("model_vpos", int'(p_vpos), m_v);
        chk("model_offset", int'(p_offset), m_off);
        chk("model_tick", int'(frame_tick), m_tick);
        chk("model_at_top", int'(at_top), (m_v == 0) ? 1 : 0);
        chk("model_at_bottom", int'(at_bottom), (m_v == HEIGHT - 1) ? 1 : 0);
    endtask

    task automatic frame();
        vsync = 1'b1; cyc();
        vsync = 1'b0; cyc(); cyc();
    endtask

    typedef struct {
        bit rst;
        bit u;
        bit d;
        int ev;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int ups[5]   = '{284, 184, 84, 0, 0};
        int downs[5] = '{484, 584, 684, 767, 767};

        // Reset, then three frames at speed 1 with vsync held two cycles each.
        reset = 1'b1; cyc(); cyc();
        chk("reset_vpos", int'(p_vpos), 384);
        chk("reset_offset", int'(p_offset), 0);
        chk("reset_tick", int'(frame_tick), 0);
        reset = 1'b0; speed = 4'd1; tick_cnt = 0;
        for (int f = 0; f < 3; f++) begin
            vsync = 1'b1; cyc(); cyc();
            vsync = 1'b0; cyc(); cyc();
        end
        chk("frames_ticks", tick_cnt, 3);
        chk("frames_offset", int'(p_offset), 3);
        chk("frames_vpos", int'(p_vpos), 384);

        // Table: single-cycle presses with clamping at both limits.
        tbl.push_back('{1, 0, 0, 384});
        for (int i = 0; i < 5; i++) begin
            tbl.push_back('{0, 1, 0, ups[i]});
            tbl.push_back('{0, 0, 0, ups[i]});
        end
        tbl.push_back('{1, 0, 0, 384});
        for (int i = 0; i < 5; i++) begin
            tbl.push_back('{0, 0, 1, downs[i]});
            tbl.push_back('{0, 0, 0, downs[i]});
        end
        tbl.push_back('{0, 1, 1, 767});
        tbl.push_back('{0, 0, 0, 767});
        speed = 4'd0;
        foreach (tbl[i]) begin
            reset = tbl[i].rst; up = tbl[i].u; down = tbl[i].d;
            cyc();
            chk($sformatf("tbl%0d_vpos", i), int'(p_vpos), tbl[i].ev);
            chk($sformatf("tbl%0d_top", i), int'(at_top), (tbl[i].ev == 0) ? 1 : 0);
            chk($sformatf("tbl%0d_bottom", i), int'(at_bottom), (tbl[i].ev == 767) ? 1 : 0);
        end

        // Hold down for 20 frames: repeat steps at frames 8 and 16.
        reset = 1'b1; up = 1'b0; down = 1'b0; cyc();
        reset = 1'b0; cyc();
        down = 1'b1; cyc();
        chk("hold_initial", int'(p_vpos), 484);
        for (int f = 0; f < 7; f++) frame();
        chk("hold_f7", int'(p_vpos), 484);
        frame();
        chk("hold_f8", int'(p_vpos), 584);
        for (int f = 0; f < 7; f++) frame();
        chk("hold_f15", int'(p_vpos), 584);
        frame();
        chk("hold_f16", int'(p_vpos), 684);
        for (int f = 0; f < 4; f++) frame();
        chk("hold_f20", int'(p_vpos), 684);
        down = 1'b0; cyc();
        for (int f = 0; f < 10; f++) frame();
        chk("hold_release", int'(p_vpos), 684);

        // Offset wrap at speed 15, then pause and speed 0 hold it.
        reset = 1'b1; cyc();
        reset = 1'b0; speed = 4'd15; pause = 1'b0;
        for (int f = 0; f < 68; f++) frame();
        chk("wrap_pre", int'(p_offset), 1020);
        frame();
        chk("wrap_post", int'(p_offset), 11);
        pause = 1'b1; tick_cnt = 0;
        frame();
        chk("pause_hold", int'(p_offset), 11);
        chk("pause_tick", tick_cnt, 1);
        pause = 1'b0; speed = 4'd0;
        frame();
        chk("speed0_hold", int'(p_offset), 11);

        // Reset while holding up: no step until released and pressed again.
        up = 1'b1; cyc();
        chk("rh_press", int'(p_vpos), 284);
        for (int f = 0; f < 3; f++) frame();
        reset = 1'b1; cyc();
        reset = 1'b0;
        for (int f = 0; f < 10; f++) frame();
        chk("rh_held", int'(p_vpos), 384);
        up = 1'b0; cyc();
        up = 1'b1; cyc();
        chk("rh_repress", int'(p_vpos), 284);
        up = 1'b0; cyc();

        // Randomized stimulus against the model.
        for (int n = 0; n < 6000; n++) begin
            reset = ($urandom_range(0, 399) == 0);
            vsync = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 15) == 0) up = ~up;
            if ($urandom_range(0, 15) == 0) down = ~down;
            if ($urandom_range(0, 31) == 0) pause = ~pause;
            if ($urandom_range(0, 7) == 0) speed = 4'($urandom_range(0, 15));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
